session_controller: RTL and testbench

SESSION_CONTROLLER -- requirements
Module: session_controller

---
 rtl/session_pkg.sv | 21 ++
 rtl/tx_byte_sender.sv | 55 +++++
 rtl/session_controller.sv | 207 ++++++++++++++++++++
 tb/tb_session_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/session_pkg.sv
// Shared FSM state encoding and default protocol bytes for the session controller.
package session_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_ID,
        ST_RX_CHAL,
        ST_START,
        ST_WAIT_PUF,
        ST_SEND_HDR,
        ST_FIFO_RD,
        ST_FIFO_WAIT,
        ST_SEND_WORD,
        ST_SEND_CSUM
    } state_t;

    localparam logic [7:0] DEF_REQUEST_ID  = 8'hAA;
    localparam logic [7:0] DEF_RESPONSE_ID = 8'hAA;
    localparam logic [7:0] DEF_CMD_EVAL    = 8'h01;

endpackage

// File: rtl/tx_byte_sender.sv
// Hands one byte to the UART: waits for tx_busy low, pulses tx_enable, then waits one cycle
// plus tx_busy low again before pulsing done; latency >= 4 cycles, stalls while tx_busy is high.
module tx_byte_sender #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] byte_dat,
    input  logic                 go,
    output logic                 done,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_enable,
    input  logic                 tx_busy
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_PULSE, S_DRAIN} snd_state_t;

    snd_state_t st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= S_IDLE;
            tx_data   <= '0;
            tx_enable <= 1'b0;
            done      <= 1'b0;
        end else begin
            tx_enable <= 1'b0;
            done      <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (go) begin
                        tx_data <= byte_dat;
                        st      <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (!tx_busy) begin
                        tx_enable <= 1'b1;
                        st        <= S_PULSE;
                    end
                end
                // Give the UART a cycle to raise tx_busy before trusting it again.
                S_PULSE: st <= S_DRAIN;
                S_DRAIN: begin
                    if (!tx_busy) begin
                        done <= 1'b1;
                        st   <= S_IDLE;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/session_controller.sv
// UART command front end for a PUF: identify reply, challenge capture, PUF launch and
// streaming of FIFO words with an XOR checksum; every TX byte is paced by tx_busy.
module session_controller
    import session_pkg::*;
#(
    parameter int         DATA_BITS       = 8,
    parameter int         CHALLENGE_BYTES = 1,
    parameter int         RESPONSE_BYTES  = 4,
    parameter logic [7:0] REQUEST_ID      = DEF_REQUEST_ID,
    parameter logic [7:0] RESPONSE_ID     = DEF_RESPONSE_ID,
    parameter logic [7:0] CMD_EVAL        = DEF_CMD_EVAL,
    parameter int         TIMEOUT_CYCLES  = 100000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_valid,
    output logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_enable,
    input  logic                          tx_busy,
    output logic [8*CHALLENGE_BYTES-1:0]  puf_challenge,
    output logic                          puf_start,
    input  logic                          puf_done,
    input  logic [8*RESPONSE_BYTES-1:0]   fifo_dout,
    input  logic                          fifo_empty,
    output logic                          fifo_re,
    output logic                          busy,
    output logic                          err_timeout
);

    generate
        if (DATA_BITS < 1 || CHALLENGE_BYTES < 1 || RESPONSE_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("session_controller: all size parameters must be at least 1");
        end
    endgenerate

    localparam int CW  = 8 * CHALLENGE_BYTES;
    localparam int WW  = 8 * RESPONSE_BYTES;
    localparam int CIW = (CHALLENGE_BYTES > 1) ? $clog2(CHALLENGE_BYTES) : 1;
    localparam int WIW = (RESPONSE_BYTES > 1) ? $clog2(RESPONSE_BYTES) : 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 state;
    logic [CW-1:0]          shadow;
    logic [CW-1:0]          chal_next;
    logic [CIW-1:0]         chal_idx;
    logic [WIW-1:0]         word_idx;
    logic [TW-1:0]          idle_cnt;
    logic [WW-1:0]          word;
    logic [7:0]             csum;
    logic [DATA_BITS-1:0]   snd_byte;
    logic [DATA_BITS-1:0]   tx_sel;
    logic                   snd_go;
    logic                   snd_done;
    logic                   go_issued;
    logic                   is_send;
    logic                   tx_step;

    assign busy      = (state != ST_IDLE);
    assign chal_next = (shadow << 8) | CW'(rx_data);
    assign is_send   = (state == ST_SEND_ID)   || (state == ST_SEND_HDR) ||
                       (state == ST_SEND_WORD) || (state == ST_SEND_CSUM);
    assign tx_step   = go_issued && snd_done;

    always_comb begin
        tx_sel = '0;
        case (state)
            ST_SEND_ID, ST_SEND_HDR: tx_sel = DATA_BITS'(RESPONSE_ID);
            ST_SEND_WORD:            tx_sel = DATA_BITS'(word[WW-1 -: 8]);
            ST_SEND_CSUM:            tx_sel = DATA_BITS'(csum);
            default:                 tx_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            shadow        <= '0;
            puf_challenge <= '0;
            chal_idx      <= '0;
            word_idx      <= '0;
            idle_cnt      <= '0;
            word          <= '0;
            csum          <= '0;
            snd_byte      <= '0;
            snd_go        <= 1'b0;
            go_issued     <= 1'b0;
            puf_start     <= 1'b0;
            fifo_re       <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            snd_go      <= 1'b0;
            puf_start   <= 1'b0;
            fifo_re     <= 1'b0;
            err_timeout <= 1'b0;

            // Each send state hands exactly one byte to the sender, then waits for done.
            if (is_send && !go_issued) begin
                snd_go    <= 1'b1;
                snd_byte  <= tx_sel;
                go_issued <= 1'b1;
                if (state == ST_SEND_WORD)
                    csum <= csum ^ word[WW-1 -: 8];
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == DATA_BITS'(REQUEST_ID)) begin
                            state <= ST_SEND_ID;
                        end else if (rx_data == DATA_BITS'(CMD_EVAL)) begin
                            state    <= ST_RX_CHAL;
                            chal_idx <= '0;
                            idle_cnt <= '0;
                        end
                    end
                end
                ST_SEND_ID: begin
                    if (tx_step) begin
                        go_issued <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_RX_CHAL: begin
                    // A byte landing on the expiry cycle wins over the timeout.
                    if (rx_valid) begin
                        shadow   <= chal_next;
                        idle_cnt <= '0;
                        if (chal_idx == CIW'(CHALLENGE_BYTES - 1)) begin
                            puf_challenge <= chal_next;
                            state         <= ST_START;
                        end else begin
                            chal_idx <= chal_idx + CIW'(1);
                        end
                    end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                ST_START: begin
                    puf_start <= 1'b1;
                    state     <= ST_WAIT_PUF;
                end
                ST_WAIT_PUF: begin
                    if (puf_done)
                        state <= ST_SEND_HDR;
                end
                ST_SEND_HDR: begin
                    csum <= '0;
                    if (tx_step) begin
                        go_issued <= 1'b0;
                        state     <= ST_FIFO_RD;
                    end
                end
                ST_FIFO_RD: begin
                    if (!fifo_empty) begin
                        fifo_re <= 1'b1;
                        state   <= ST_FIFO_WAIT;
                    end else begin
                        state <= ST_SEND_CSUM;
                    end
                end
                ST_FIFO_WAIT: begin
                    // fifo_re is still high on the first cycle here; data lands the cycle after.
                    if (!fifo_re) begin
                        word     <= fifo_dout;
                        word_idx <= '0;
                        state    <= ST_SEND_WORD;
                    end
                end
                ST_SEND_WORD: begin
                    if (tx_step) begin
                        go_issued <= 1'b0;
                        word      <= word << 8;
                        if (word_idx == WIW'(RESPONSE_BYTES - 1))
                            state <= ST_FIFO_RD;
                        else
                            word_idx <= word_idx + WIW'(1);
                    end
                end
                ST_SEND_CSUM: begin
                    if (tx_step) begin
                        go_issued <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tx_byte_sender #(
        .DATA_BITS (DATA_BITS)
    ) u_tx_byte_sender (
        .clk       (clk),
        .reset     (reset),
        .byte_dat  (snd_byte),
        .go        (snd_go),
        .done      (snd_done),
        .tx_data   (tx_data),
        .tx_enable (tx_enable),
        .tx_busy   (tx_busy)
    );

endmodule

// File: tb/tb_session_controller.sv
// Directed bench for session_controller: transaction table plus timeout, busy-hold and reset sequences.
module tb_session_controller;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_enable;
    logic        tx_busy;
    logic [15:0] puf_challenge;
    logic        puf_start;
    logic        puf_done = 1'b0;
    logic [31:0] fifo_dout = '0;
    logic        fifo_empty;
    logic        fifo_re;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    session_controller #(
        .DATA_BITS       (8),
        .CHALLENGE_BYTES (2),
        .RESPONSE_BYTES  (4),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_enable     (tx_enable),
        .tx_busy       (tx_busy),
        .puf_challenge (puf_challenge),
        .puf_start     (puf_start),
        .puf_done      (puf_done),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_re       (fifo_re),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    // UART, PUF and FIFO models plus event counters.
    logic [2:0]  ub_cnt = '0;
    logic        hold_busy = 1'b0;
    logic [7:0]  tx_log [$];
    int          puf_cnt = 0, re_cnt = 0, err_cnt = 0, viol_cnt = 0;
    logic [31:0] fmem [16];
    logic [3:0]  wr_ptr = '0;
    logic [3:0]  rd_ptr = '0;

    assign tx_busy    = (ub_cnt != 3'd0) || hold_busy;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (tx_enable) begin
            tx_log.push_back(tx_data);
            if (tx_busy) viol_cnt++;
            ub_cnt <= 3'd4;
        end else if (ub_cnt != 3'd0) begin
            ub_cnt <= ub_cnt - 3'd1;
        end
        puf_done <= puf_start;
        if (puf_start) puf_cnt++;
        if (err_timeout) err_cnt++;
        if (fifo_re && fifo_empty) viol_cnt++;
        if (!reset) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_re) begin
            re_cnt++;
            fifo_dout <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] tx_at(input int idx);
        if (idx < tx_log.size()) return 32'(tx_log[idx]);
        return 32'hFFFF_FFFF;
    endfunction

    typedef struct packed {
        logic [0:2][7:0]  rx;
        logic [1:0]       n_rx;
        logic [0:1][31:0] words;
        logic [1:0]       n_words;
        logic [0:9][7:0]  tx;
        logic [3:0]       n_tx;
        logic [15:0]      chal;
        logic [1:0]       n_puf;
        logic [1:0]       n_re;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int tx0, p0, r0, e0, tx_n, r_n, n;
        vec_t v;

        vecs[0] = '{rx: {8'hAA, 16'h0}, n_rx: 2'd1, words: 64'h0, n_words: 2'd0,
                    tx: {8'hAA, 72'h0}, n_tx: 4'd1, chal: 16'h0000, n_puf: 2'd0, n_re: 2'd0};
        vecs[1] = '{rx: {8'h01, 8'h12, 8'h34}, n_rx: 2'd3, words: {32'hDEADBEEF, 32'h0}, n_words: 2'd1,
                    tx: {8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 32'h0}, n_tx: 4'd6,
                    chal: 16'h1234, n_puf: 2'd1, n_re: 2'd1};
        vecs[2] = '{rx: {8'h01, 8'hAB, 8'hCD}, n_rx: 2'd3, words: 64'h0, n_words: 2'd0,
                    tx: {8'hAA, 8'h00, 64'h0}, n_tx: 4'd2, chal: 16'hABCD, n_puf: 2'd1, n_re: 2'd0};
        vecs[3] = '{rx: {8'h55, 16'h0}, n_rx: 2'd1, words: 64'h0, n_words: 2'd0,
                    tx: 80'h0, n_tx: 4'd0, chal: 16'hABCD, n_puf: 2'd0, n_re: 2'd0};
        vecs[4] = '{rx: {8'h01, 8'h00, 8'h01}, n_rx: 2'd3, words: {32'h11223344, 32'hA5A5A5A5}, n_words: 2'd2,
                    tx: {8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h44}, n_tx: 4'd10,
                    chal: 16'h0001, n_puf: 2'd1, n_re: 2'd2};
        vecs[5] = '{rx: {8'hAA, 16'h0}, n_rx: 2'd1, words: 64'h0, n_words: 2'd0,
                    tx: {8'hAA, 72'h0}, n_tx: 4'd1, chal: 16'h0001, n_puf: 2'd0, n_re: 2'd0};

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_enable", 32'(tx_enable), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_puf_start", 32'(puf_start), 32'd0);
        check("rst_puf_challenge", 32'(puf_challenge), 32'd0);
        check("rst_fifo_re", 32'(fifo_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v   = vecs[i];
            tx0 = tx_log.size();
            p0  = puf_cnt;
            r0  = re_cnt;
            e0  = err_cnt;
            for (int w = 0; w < int'(v.n_words); w++) begin
                fmem[wr_ptr] = v.words[w];
                wr_ptr = wr_ptr + 4'd1;
            end
            for (int k = 0; k < int'(v.n_rx); k++) begin
                send_byte(v.rx[k]);
                repeat (2) @(negedge clk);
            end
            wait_idle($sformatf("v%0d_idle", i));
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_tx_count", i), 32'(tx_log.size() - tx0), 32'(v.n_tx));
            for (int k = 0; k < int'(v.n_tx); k++)
                check($sformatf("v%0d_tx%0d", i, k), tx_at(tx0 + k), 32'(v.tx[k]));
            check($sformatf("v%0d_puf_start", i), 32'(puf_cnt - p0), 32'(v.n_puf));
            check($sformatf("v%0d_fifo_re", i), 32'(re_cnt - r0), 32'(v.n_re));
            check($sformatf("v%0d_err_timeout", i), 32'(err_cnt - e0), 32'd0);
            check($sformatf("v%0d_challenge", i), 32'(puf_challenge), 32'(v.chal));
        end

        // Bytes arriving exactly on the expiry cycle are accepted and restart the count.
        tx0 = tx_log.size();
        e0  = err_cnt;
        send_byte(8'h01);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'hC3);
        repeat (TMO - 1) @(negedge clk);
        send_byte(8'h5A);
        wait_idle("edge_idle");
        repeat (10) @(negedge clk);
        check("edge_err_timeout", 32'(err_cnt - e0), 32'd0);
        check("edge_challenge", 32'(puf_challenge), 32'h0000C35A);
        check("edge_tx_count", 32'(tx_log.size() - tx0), 32'd2);
        check("edge_tx0", tx_at(tx0), 32'h000000AA);
        check("edge_tx1", tx_at(tx0 + 1), 32'h00000000);

        // Silence after a partial challenge.
        tx0 = tx_log.size();
        e0  = err_cnt;
        p0  = puf_cnt;
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_early_err", 32'(err_cnt - e0), 32'd0);
        check("tmo_early_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("tmo_pulse", 32'(err_timeout), 32'd1);
        check("tmo_busy_low", 32'(busy), 32'd0);
        @(negedge clk);
        check("tmo_pulse_end", 32'(err_timeout), 32'd0);
        repeat (5) @(negedge clk);
        check("tmo_err_count", 32'(err_cnt - e0), 32'd1);
        check("tmo_challenge_kept", 32'(puf_challenge), 32'h0000C35A);
        check("tmo_no_puf", 32'(puf_cnt - p0), 32'd0);
        check("tmo_no_tx", 32'(tx_log.size() - tx0), 32'd0);

        // Unknown byte, then an identify held off by a long tx_busy.
        tx0 = tx_log.size();
        send_byte(8'h55);
        repeat (5) @(negedge clk);
        check("hold_unknown_busy", 32'(busy), 32'd0);
        hold_busy = 1'b1;
        send_byte(8'hAA);
        repeat (50) @(negedge clk);
        check("hold_no_tx", 32'(tx_log.size() - tx0), 32'd0);
        check("hold_busy_high", 32'(busy), 32'd1);
        hold_busy = 1'b0;
        wait_idle("hold_idle");
        repeat (10) @(negedge clk);
        check("hold_tx_count", 32'(tx_log.size() - tx0), 32'd1);
        check("hold_tx0", tx_at(tx0), 32'h000000AA);

        // Reset while the second word is being sent.
        tx0 = tx_log.size();
        fmem[wr_ptr] = 32'h01020304;
        wr_ptr = wr_ptr + 4'd1;
        fmem[wr_ptr] = 32'h05060708;
        wr_ptr = wr_ptr + 4'd1;
        send_byte(8'h01);
        repeat (2) @(negedge clk);
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        send_byte(8'h02);
        n = 0;
        while (tx_log.size() - tx0 < 6 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_reached", 32'(tx_log.size() - tx0 >= 6), 32'd1);
        check("rstmid_word2_byte0", tx_at(tx0 + 5), 32'h00000005);
        reset = 1'b0;
        tx_n  = tx_log.size();
        r_n   = re_cnt;
        repeat (3) @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_challenge", 32'(puf_challenge), 32'd0);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        check("rstmid_no_tx", 32'(tx_log.size() - tx_n), 32'd0);
        check("rstmid_no_fifo_re", 32'(re_cnt - r_n), 32'd0);
        check("rstmid_idle", 32'(busy), 32'd0);
        tx0 = tx_log.size();
        send_byte(8'hAA);
        wait_idle("rstmid_id_idle");
        repeat (10) @(negedge clk);
        check("rstmid_id_count", 32'(tx_log.size() - tx0), 32'd1);
        check("rstmid_id_tx0", tx_at(tx0), 32'h000000AA);

        check("protocol_violations", 32'(viol_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
